// File: rtl/multicycle_control_if.sv
// Handshake bundle between the multicycle controller and its datapath/memory.
// The master side is the controller: it samples the decoded instruction fields,
// the ALU zero flag and the memory acknowledge, and drives all control strobes.
interface multicycle_control_if #(
    parameter int ALUCT_W = 4,
    parameter int CNT_W   = 32
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               mem_ack;
    logic               pc_wen;
    logic [1:0]         pc_src;
    logic               ir_wen;
    logic               iord;
    logic               mem_ren;
    logic               mem_wen;
    logic               rf_wen;
    logic               rf_dst;
    logic               data_rf;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUCT_W-1:0] alu_ct;
    logic [3:0]         state;
    logic [CNT_W-1:0]   inst_cnt;
    logic               illegal;

    modport master (
        input  op, funct, zero, mem_ack,
        output pc_wen, pc_src, ir_wen, iord, mem_ren, mem_wen,
               rf_wen, rf_dst, data_rf, alu_src_a, alu_src_b, alu_ct,
               state, inst_cnt, illegal
    );

    modport slave (
        output op, funct, zero, mem_ack,
        input  pc_wen, pc_src, ir_wen, iord, mem_ren, mem_wen,
               rf_wen, rf_dst, data_rf, alu_src_a, alu_src_b, alu_ct,
               state, inst_cnt, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM (R-type, lw, sw, beq, j, addiu).
// Outputs are decoded from the current state, with mem_ack and zero folded in
// where a state waits on memory or resolves a branch. A retired-instruction
// counter ticks on every legal instruction's final transition back to fetch.
// Optional feature: define MULTICYCLE_CONTROL_BNE_EN to add bne (opcode 000101),
// which reuses the branch state with the zero test inverted.
module multicycle_control #(
    parameter int ALUCT_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_control_if.master  bus
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_MA  = 4'd2,
        S_MR  = 4'd3,
        S_MWB = 4'd4,
        S_MW  = 4'd5,
        S_EX  = 4'd6,
        S_RWB = 4'd7,
        S_BR  = 4'd8,
        S_JP  = 4'd9,
        S_IEX = 4'd10,
        S_IWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

`ifdef MULTICYCLE_CONTROL_BNE_EN
    localparam logic BNE_EN = 1'b1;
`else
    localparam logic BNE_EN = 1'b0;
`endif

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_instCnt;

    logic       w_pcWen;
    logic [1:0] w_pcSrc;
    logic       w_irWen;
    logic       w_iord;
    logic       w_memRen;
    logic       w_memWen;
    logic       w_rfWen;
    logic       w_rfDst;
    logic       w_dataRf;
    logic       w_aluSrcA;
    logic [1:0] w_aluSrcB;
    logic [3:0] w_aluOp;
    logic       w_illegal;
    logic       w_retire;
    logic       w_isBne;

    assign w_isBne = BNE_EN && (bus.op == OP_BNE);

    // State register; reset abandons any instruction, including memory waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Retired-instruction counter, wrapping naturally at its width.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instCnt <= '0;
        end else if (w_retire) begin
            r_instCnt <= r_instCnt + CNT_W'(1);
        end
    end

    // Next-state and per-state control decode; everything idles at zero unless the state says otherwise.
    always_comb begin
        w_nextState = r_state;
        w_pcWen     = 1'b0;
        w_pcSrc     = 2'b00;
        w_irWen     = 1'b0;
        w_iord      = 1'b0;
        w_memRen    = 1'b0;
        w_memWen    = 1'b0;
        w_rfWen     = 1'b0;
        w_rfDst     = 1'b0;
        w_dataRf    = 1'b0;
        w_aluSrcA   = 1'b0;
        w_aluSrcB   = 2'b00;
        w_aluOp     = ALU_AND;
        w_illegal   = 1'b0;
        w_retire    = 1'b0;

        case (r_state)
            S_IF: begin
                w_memRen  = 1'b1;
                w_aluSrcB = 2'b01;
                w_aluOp   = ALU_ADD;
                if (bus.mem_ack) begin
                    w_irWen     = 1'b1;
                    w_pcWen     = 1'b1;
                    w_nextState = S_ID;
                end
            end
            S_ID: begin
                w_aluSrcB = 2'b11;
                w_aluOp   = ALU_ADD;
                case (bus.op)
                    OP_LW, OP_SW: w_nextState = S_MA;
                    OP_R:         w_nextState = S_EX;
                    OP_BEQ:       w_nextState = S_BR;
                    OP_J:         w_nextState = S_JP;
                    OP_ADDIU:     w_nextState = S_IEX;
                    default: begin
                        if (w_isBne) begin
                            w_nextState = S_BR;
                        end else begin
                            w_illegal   = 1'b1;
                            w_nextState = S_IF;
                        end
                    end
                endcase
            end
            S_MA: begin
                w_aluSrcA   = 1'b1;
                w_aluSrcB   = 2'b10;
                w_aluOp     = ALU_ADD;
                w_nextState = (bus.op == OP_LW) ? S_MR : S_MW;
            end
            S_MR: begin
                w_memRen = 1'b1;
                w_iord   = 1'b1;
                if (bus.mem_ack) begin
                    w_nextState = S_MWB;
                end
            end
            S_MW: begin
                w_memWen = 1'b1;
                w_iord   = 1'b1;
                if (bus.mem_ack) begin
                    w_nextState = S_IF;
                    w_retire    = 1'b1;
                end
            end
            S_MWB: begin
                w_rfWen     = 1'b1;
                w_dataRf    = 1'b1;
                w_nextState = S_IF;
                w_retire    = 1'b1;
            end
            S_EX: begin
                w_aluSrcA   = 1'b1;
                w_nextState = S_RWB;
                casez (bus.funct)
                    6'b10000?: w_aluOp = ALU_ADD;
                    6'b10001?: w_aluOp = ALU_SUB;
                    6'b100100: w_aluOp = ALU_AND;
                    6'b100101: w_aluOp = ALU_OR;
                    6'b101010: w_aluOp = ALU_SLT;
                    default: begin
                        w_illegal   = 1'b1;
                        w_nextState = S_IF;
                    end
                endcase
            end
            S_RWB: begin
                w_rfWen     = 1'b1;
                w_rfDst     = 1'b1;
                w_nextState = S_IF;
                w_retire    = 1'b1;
            end
            S_BR: begin
                w_aluSrcA   = 1'b1;
                w_aluOp     = ALU_SUB;
                w_pcSrc     = 2'b01;
                w_pcWen     = w_isBne ? ~bus.zero : bus.zero;
                w_nextState = S_IF;
                w_retire    = 1'b1;
            end
            S_JP: begin
                w_pcSrc     = 2'b10;
                w_pcWen     = 1'b1;
                w_nextState = S_IF;
                w_retire    = 1'b1;
            end
            S_IEX: begin
                w_aluSrcA   = 1'b1;
                w_aluSrcB   = 2'b10;
                w_aluOp     = ALU_ADD;
                w_nextState = S_IWB;
            end
            S_IWB: begin
                w_rfWen     = 1'b1;
                w_nextState = S_IF;
                w_retire    = 1'b1;
            end
            default: begin
                w_nextState = S_IF;
            end
        endcase
    end

    // Write/request strobes and the illegal pulse are held off while reset is asserted.
    assign bus.pc_wen    = w_pcWen  & ~rst;
    assign bus.ir_wen    = w_irWen  & ~rst;
    assign bus.mem_ren   = w_memRen & ~rst;
    assign bus.mem_wen   = w_memWen & ~rst;
    assign bus.rf_wen    = w_rfWen  & ~rst;
    assign bus.illegal   = w_illegal & ~rst;
    assign bus.pc_src    = w_pcSrc;
    assign bus.iord      = w_iord;
    assign bus.rf_dst    = w_rfDst;
    assign bus.data_rf   = w_dataRf;
    assign bus.alu_src_a = w_aluSrcA;
    assign bus.alu_src_b = w_aluSrcB;
    assign bus.alu_ct    = ALUCT_W'(w_aluOp);
    assign bus.state     = r_state;
    assign bus.inst_cnt  = r_instCnt;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Each instruction is expanded into the list of
// cycles it must occupy (phases from the instruction class, stretched by memory
// wait cycles), and a compare process checks two DUT instances cycle by cycle:
// the default build and a narrow-counter / wide-ALU-control build.
module tb_multicycle_control;

    logic clk;
    logic rst;

    multicycle_control_if #(.ALUCT_W(4), .CNT_W(32)) bus ();
    multicycle_control_if #(.ALUCT_W(6), .CNT_W(4))  bus2 ();

    multicycle_control #(.ALUCT_W(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    multicycle_control #(.ALUCT_W(6), .CNT_W(4)) dutSmall (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    assign bus2.op      = bus.op;
    assign bus2.funct   = bus.funct;
    assign bus2.zero    = bus.zero;
    assign bus2.mem_ack = bus.mem_ack;

`ifdef MULTICYCLE_CONTROL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       ack;
        logic       zero;
        logic [5:0] op;
        logic [5:0] funct;
        logic [3:0] st;
        logic       pcWen;
        logic [1:0] pcSrc;
        logic       irWen;
        logic       iord;
        logic       memRen;
        logic       memWen;
        logic       rfWen;
        logic       rfDst;
        logic       dataRf;
        logic       srcA;
        logic [1:0] srcB;
        logic [3:0] aluCt;
        logic       illegal;
        logic       retire;
    } cyc_t;

    cyc_t        expQ[$];
    cyc_t        cur;
    bit          curValid;
    logic [31:0] expCnt;
    int          errCount;
    int          checkCount;
    int          cycleNo;

    logic [5:0]  bldOp;
    logic [5:0]  bldFunct;
    logic        bldZero;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycleNo, act, exp);
        end
    endtask

    // A blank cycle record for the current instruction: everything zero, random mem_ack.
    function automatic cyc_t mk(input int st);
        cyc_t c;
        c.rst = 1'b0;  c.ack = 1'($urandom_range(0, 1));
        c.zero = bldZero; c.op = bldOp; c.funct = bldFunct;
        c.st = 4'(st); c.pcWen = 0; c.pcSrc = 0; c.irWen = 0; c.iord = 0;
        c.memRen = 0; c.memWen = 0; c.rfWen = 0; c.rfDst = 0; c.dataRf = 0;
        c.srcA = 0; c.srcB = 0; c.aluCt = 0; c.illegal = 0; c.retire = 0;
        return c;
    endfunction

    // ALU operation named by an R-type funct value; -1 for unsupported.
    function automatic int functAlu(input int f);
        case (f)
            32, 33:  return 2;
            34, 35:  return 6;
            36:      return 0;
            37:      return 1;
            42:      return 7;
            default: return -1;
        endcase
    endfunction

    // Fetch phase: waits with mem_ack low, then the acknowledged fetch cycle.
    task automatic pushFetch(input int ifWait);
        cyc_t c;
        for (int w = 0; w <= ifWait; w++) begin
            c = mk(0);
            c.memRen = 1; c.srcB = 2'b01; c.aluCt = 4'b0010;
            c.ack = (w == ifWait);
            if (w == ifWait) begin c.irWen = 1; c.pcWen = 1; end
            expQ.push_back(c);
        end
    endtask

    // Memory access wait: memWait unacknowledged cycles then one acknowledged cycle.
    task automatic pushMem(input int st, input int memWait, input bit isWrite, input bit retireLast);
        cyc_t c;
        for (int w = 0; w <= memWait; w++) begin
            c = mk(st);
            c.iord = 1;
            if (isWrite) c.memWen = 1; else c.memRen = 1;
            c.ack = (w == memWait);
            c.retire = retireLast && (w == memWait);
            expQ.push_back(c);
        end
    endtask

    // Expand one instruction into the cycles it must take and their outputs.
    task automatic buildInstr(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                              input int ifWait, input int memWait);
        cyc_t c;
        int   alu;
        bldOp = op; bldFunct = funct; bldZero = zero;
        pushFetch(ifWait);
        c = mk(1); c.srcB = 2'b11; c.aluCt = 4'b0010;
        if (op == 6'd35 || op == 6'd43) begin
            expQ.push_back(c);
            c = mk(2); c.srcA = 1; c.srcB = 2'b10; c.aluCt = 4'b0010; expQ.push_back(c);
            if (op == 6'd35) begin
                pushMem(3, memWait, 1'b0, 1'b0);
                c = mk(4); c.rfWen = 1; c.dataRf = 1; c.retire = 1; expQ.push_back(c);
            end else begin
                pushMem(5, memWait, 1'b1, 1'b1);
            end
        end else if (op == 6'd0) begin
            expQ.push_back(c);
            alu = functAlu(int'(funct));
            c = mk(6); c.srcA = 1;
            if (alu < 0) begin
                c.illegal = 1; expQ.push_back(c);
            end else begin
                c.aluCt = 4'(alu); expQ.push_back(c);
                c = mk(7); c.rfWen = 1; c.rfDst = 1; c.retire = 1; expQ.push_back(c);
            end
        end else if (op == 6'd4 || (BNE_EN && op == 6'd5)) begin
            expQ.push_back(c);
            c = mk(8); c.srcA = 1; c.aluCt = 4'b0110; c.pcSrc = 2'b01;
            c.pcWen = (op == 6'd4) ? zero : !zero; c.retire = 1; expQ.push_back(c);
        end else if (op == 6'd2) begin
            expQ.push_back(c);
            c = mk(9); c.pcSrc = 2'b10; c.pcWen = 1; c.retire = 1; expQ.push_back(c);
        end else if (op == 6'd9) begin
            expQ.push_back(c);
            c = mk(10); c.srcA = 1; c.srcB = 2'b10; c.aluCt = 4'b0010; expQ.push_back(c);
            c = mk(11); c.rfWen = 1; c.retire = 1; expQ.push_back(c);
        end else begin
            c.illegal = 1; expQ.push_back(c);
        end
    endtask

    // Cycles spent in reset: fetch-state decode visible, strobes held low.
    task automatic buildReset(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = mk(0); c.rst = 1; c.srcB = 2'b01; c.aluCt = 4'b0010;
            expQ.push_back(c);
        end
    endtask

    // A store whose memory wait is cut short by reset.
    task automatic buildSwAbort(input int memWait);
        cyc_t c;
        bldOp = 6'd43; bldFunct = 6'($urandom); bldZero = 1'($urandom);
        pushFetch(0);
        c = mk(1); c.srcB = 2'b11; c.aluCt = 4'b0010; expQ.push_back(c);
        c = mk(2); c.srcA = 1; c.srcB = 2'b10; c.aluCt = 4'b0010; expQ.push_back(c);
        for (int w = 0; w < memWait; w++) begin
            c = mk(5); c.memWen = 1; c.iord = 1; c.ack = 0; expQ.push_back(c);
        end
        c = mk(5); c.iord = 1; c.rst = 1; expQ.push_back(c);
    endtask

    // Play queued cycles onto the DUT inputs and advance the retired count model.
    task automatic applyStimulus();
        cyc_t c;
        while (expQ.size() > 0) begin
            c = expQ.pop_front();
            rst = c.rst;
            bus.op = c.op; bus.funct = c.funct; bus.zero = c.zero; bus.mem_ack = c.ack;
            cur = c; curValid = 1'b1;
            @(posedge clk);
            #1;
            cycleNo++;
            if (c.rst) expCnt = 0;
            else if (c.retire) expCnt = expCnt + 1;
        end
    endtask

    // Compare both DUTs against the current expected cycle on the falling edge.
    always @(negedge clk) begin
        if (curValid) begin
            checkOutput("outputs",
                {42'd0, bus.state, bus.pc_wen, bus.pc_src, bus.ir_wen, bus.iord, bus.mem_ren,
                 bus.mem_wen, bus.rf_wen, bus.rf_dst, bus.data_rf, bus.alu_src_a, bus.alu_src_b,
                 bus.alu_ct, bus.illegal},
                {42'd0, cur.st, cur.pcWen, cur.pcSrc, cur.irWen, cur.iord, cur.memRen,
                 cur.memWen, cur.rfWen, cur.rfDst, cur.dataRf, cur.srcA, cur.srcB,
                 cur.aluCt, cur.illegal});
            checkOutput("inst_cnt", {32'd0, bus.inst_cnt}, {32'd0, expCnt});
            checkOutput("small_outputs",
                {40'd0, bus2.state, bus2.pc_wen, bus2.pc_src, bus2.ir_wen, bus2.iord, bus2.mem_ren,
                 bus2.mem_wen, bus2.rf_wen, bus2.rf_dst, bus2.data_rf, bus2.alu_src_a,
                 bus2.alu_src_b, bus2.alu_ct, bus2.illegal},
                {40'd0, cur.st, cur.pcWen, cur.pcSrc, cur.irWen, cur.iord, cur.memRen,
                 cur.memWen, cur.rfWen, cur.rfDst, cur.dataRf, cur.srcA, cur.srcB,
                 2'b00, cur.aluCt, cur.illegal});
            checkOutput("small_inst_cnt", {60'd0, bus2.inst_cnt}, {60'd0, expCnt[3:0]});
        end
    end

    // Directed scenarios with literal expectations, then randomized instruction mix.
    initial begin
        logic [5:0] opList [9];
        logic [5:0] op;
        logic [5:0] funct;
        int         len;
        errCount = 0; checkCount = 0; cycleNo = 0; curValid = 1'b0; expCnt = 0;
        rst = 1'b1; bus.op = 0; bus.funct = 0; bus.zero = 0; bus.mem_ack = 0;
        @(posedge clk);
        #1;

        buildReset(2);
        applyStimulus();

        buildInstr(6'b000000, 6'b100001, 1'b0, 0, 0);
        len = expQ.size();
        checkOutput("addu_len", 64'(len), 64'd4);
        checkOutput("addu_ex_alu", 64'(expQ[2].aluCt), 64'h2);
        checkOutput("addu_ex_state", 64'(expQ[2].st), 64'd6);
        applyStimulus();
        checkOutput("addu_cnt_dut", 64'(bus.inst_cnt), 64'd1);
        checkOutput("addu_back_to_if", 64'(bus.state), 64'd0);

        buildInstr(6'b100011, 6'd0, 1'b0, 0, 2);
        checkOutput("lw_wait_len", 64'(expQ.size()), 64'd7);
        applyStimulus();

        buildInstr(6'b000100, 6'd0, 1'b1, 0, 0);
        checkOutput("beq_len", 64'(expQ.size()), 64'd3);
        applyStimulus();
        buildInstr(6'b000100, 6'd0, 1'b0, 0, 0);
        applyStimulus();
        checkOutput("beq_cnt_dut", 64'(bus.inst_cnt), 64'd4);

        buildInstr(6'b111111, 6'd0, 1'b0, 0, 0);
        checkOutput("illegal_op_len", 64'(expQ.size()), 64'd2);
        applyStimulus();
        buildInstr(6'b000000, 6'b000111, 1'b0, 1, 0);
        checkOutput("illegal_funct_len", 64'(expQ.size()), 64'd4);
        applyStimulus();
        checkOutput("illegal_cnt_dut", 64'(bus.inst_cnt), 64'd4);

        buildInstr(6'b101011, 6'd0, 1'b0, 0, 0);
        checkOutput("sw_len", 64'(expQ.size()), 64'd4);
        applyStimulus();
        buildInstr(6'b001001, 6'd0, 1'b0, 0, 0);
        checkOutput("addiu_len", 64'(expQ.size()), 64'd4);
        applyStimulus();
        buildInstr(6'b100011, 6'd0, 1'b0, 0, 0);
        checkOutput("lw_len", 64'(expQ.size()), 64'd5);
        applyStimulus();

        buildSwAbort(2);
        applyStimulus();
        checkOutput("abort_cnt_dut", 64'(bus.inst_cnt), 64'd0);
        checkOutput("abort_state_dut", 64'(bus.state), 64'd0);
        checkOutput("abort_memwen_dut", 64'(bus.mem_wen), 64'd0);

        for (int i = 0; i < 16; i++) begin
            buildInstr(6'b000010, 6'($urandom), 1'($urandom), 0, 0);
            applyStimulus();
        end
        checkOutput("j16_small_cnt_dut", 64'(bus2.inst_cnt), 64'd0);
        checkOutput("j16_cnt_dut", 64'(bus.inst_cnt), 64'd16);

        buildInstr(6'b000101, 6'd0, 1'b0, 0, 0);
        checkOutput("bne_len", 64'(expQ.size()), BNE_EN ? 64'd3 : 64'd2);
        applyStimulus();
        checkOutput("bne_cnt_dut", 64'(bus.inst_cnt), BNE_EN ? 64'd17 : 64'd16);

        opList = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd9, 6'd5, 6'd63, 6'd17};
        for (int i = 0; i < 220; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                buildSwAbort($urandom_range(0, 3));
            end else begin
                op = opList[$urandom_range(0, 8)];
                if ($urandom_range(0, 7) == 0) op = 6'($urandom);
                case ($urandom_range(0, 6))
                    0: funct = 6'd32;
                    1: funct = 6'd35;
                    2: funct = 6'd36;
                    3: funct = 6'd37;
                    4: funct = 6'd42;
                    5: funct = 6'd33;
                    default: funct = 6'($urandom);
                endcase
                buildInstr(op, funct, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
            end
            applyStimulus();
        end

        curValid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
